// File: rtl/plane_line_setup.sv
// rtl/plane_line_setup.sv - per-scanline perspective setup: dx = sat(2^NUM_SHIFT/denom), u0 = -(dx*CENTER)
//
// Purpose: computes the horizontal texture step and the left-edge texture
// coordinate for one scanline of the checkerboard plane. A restoring divider
// (NUM_SHIFT+1 cycles) is followed by a shift-add multiply by CENTER
// (CENTER_W cycles) and one output-register cycle: 28 cycles with defaults.
//
// Ports:
//   clk48   in   1        system clock
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        one-cycle request; denom sampled on the same edge
//   denom   in   DEN_W    unsigned depth denominator
//   busy    out  1        computation in progress (DIV/MUL/DONE)
//   valid   out  1        one-cycle pulse when dx_out/u0_out are new
//   dx_out  out  RECIP_W  horizontal step, held between results
//   u0_out  out  U_W      start coordinate (two's complement), held between results
module plane_line_setup #(
  parameter int DEN_W     = 10,
  parameter int NUM_SHIFT = 16,
  parameter int RECIP_W   = 11,
  parameter int CENTER    = 610,
  parameter int CENTER_W  = 10,
  parameter int U_W       = 21
) (
  input  logic               clk48,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DEN_W-1:0]   denom,
  output logic               busy,
  output logic               valid,
  output logic [RECIP_W-1:0] dx_out,
  output logic [U_W-1:0]     u0_out
);

  localparam int CNT_MAX = (NUM_SHIFT > CENTER_W) ? NUM_SHIFT : CENTER_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CENTER_W-1:0] CENTER_BITS = CENTER_W'(CENTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DEN_W-1:0]     den_r;
  logic [DEN_W:0]       rem;
  logic [NUM_SHIFT-1:0] quo;
  logic [CNT_W-1:0]     cnt;
  logic [RECIP_W-1:0]   dx;
  logic [U_W-1:0]       mcand;
  logic [CENTER_W-1:0]  mplier;
  logic [U_W-1:0]       acc;

  // Divider step. The numerator 2^NUM_SHIFT contributes a single 1 bit on
  // the first step (cnt still at NUM_SHIFT). trial is one bit wider than
  // rem so denom = 0 never loses the compare; the stored remainder is
  // truncated, which only matters for that degenerate case and does not
  // affect its all-ones quotient.
  logic [DEN_W+1:0]     trial;
  logic [DEN_W+1:0]     den_ext;
  logic                 ge;
  logic [NUM_SHIFT:0]   q_next;
  logic                 sat;
  logic [RECIP_W-1:0]   dx_sat;

  always_comb begin
    trial   = {rem, (cnt == CNT_W'(NUM_SHIFT))};
    den_ext = {2'b00, den_r};
    ge      = (trial >= den_ext);
    q_next  = {quo, ge};
    sat     = |q_next[NUM_SHIFT:RECIP_W];
    dx_sat  = sat ? '1 : q_next[RECIP_W-1:0];
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = DIV;
      DIV: begin
        if (start)              state_next = DIV;
        else if (cnt == '0)     state_next = MUL;
      end
      MUL: begin
        if (start)                             state_next = DIV;
        else if (cnt == CNT_W'(CENTER_W - 1))  state_next = DONE;
      end
      DONE: state_next = start ? DIV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      den_r  <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      dx     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      valid  <= 1'b0;
      dx_out <= '0;
      u0_out <= '0;
    end else begin
      valid <= 1'b0;
      // DONE publishes the finishing result even if a new start arrives.
      if (state == DONE) begin
        dx_out <= dx;
        u0_out <= -acc;
        valid  <= 1'b1;
      end
      // A start in any state (re)loads the divider; pending work is dropped.
      if (start) begin
        den_r <= denom;
        rem   <= '0;
        quo   <= '0;
        cnt   <= CNT_W'(NUM_SHIFT);
      end else begin
        case (state)
          DIV: begin
            rem <= (DEN_W+1)'(ge ? (trial - den_ext) : trial);
            quo <= q_next[NUM_SHIFT-1:0];
            if (cnt == '0) begin
              dx     <= dx_sat;
              mcand  <= U_W'(dx_sat);
              mplier <= CENTER_BITS;
              acc    <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          MUL: begin
            // CENTER is consumed LSB first; mcand carries dx << k.
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plane_line_setup.sv
// tb/tb_plane_line_setup.sv - self-checking bench for plane_line_setup
module tb_plane_line_setup;

  localparam int DEN_W   = 10;
  localparam int RECIP_W = 11;
  localparam int U_W     = 21;
  localparam int LAT     = 28;

  logic               clk48 = 1'b0;
  logic               rst_n;
  logic               start;
  logic [DEN_W-1:0]   denom;
  logic               busy;
  logic               valid;
  logic [RECIP_W-1:0] dx_out;
  logic [U_W-1:0]     u0_out;

  int tests = 0;
  int failed = 0;

  plane_line_setup dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .start (start),
    .denom (denom),
    .busy  (busy),
    .valid (valid),
    .dx_out(dx_out),
    .u0_out(u0_out)
  );

  always #5 clk48 = ~clk48;

  function automatic int model_dx(input int d);
    int q;
    if (d == 0) return 2047;
    q = 65536 / d;
    return (q > 2047) ? 2047 : q;
  endfunction

  function automatic int model_u0(input int d);
    return (-(model_dx(d) * 610)) & ((1 << U_W) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one request and watches 45 cycles after the start edge.
  task automatic single(input string tag, input int d);
    int vat, vcnt, bcnt;
    logic [31:0] dxv, u0v;
    vat = -1; vcnt = 0; bcnt = 0; dxv = 0; u0v = 0;
    @(negedge clk48);
    start = 1'b1; denom = DEN_W'(d);
    for (int c = 0; c < 45; c++) begin
      @(negedge clk48);           // after edge E+c
      start = 1'b0;
      if (busy) bcnt++;
      if (valid) begin
        vcnt++;
        if (vat < 0) begin vat = c; dxv = 32'(dx_out); u0v = 32'(u0_out); end
      end
    end
    chk({tag, "_valid_at"}, vat, LAT);
    chk({tag, "_valid_cnt"}, vcnt, 1);
    chk({tag, "_busy_cycles"}, bcnt, LAT);
    chk({tag, "_dx"}, dxv, model_dx(d));
    chk({tag, "_u0"}, u0v, model_u0(d));
  endtask

  initial begin
    int vcnt, vat, d, sent;
    logic [31:0] hold_dx, hold_u0;
    bit hold_ok;
    int exp_q[$];

    // Reset with start pulsing.
    rst_n = 1'b0; start = 1'b0; denom = '0;
    repeat (2) @(negedge clk48);
    start = 1'b1; denom = 10'd33;
    @(negedge clk48);
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dx", dx_out, 0);
    chk("rst_u0", u0_out, 0);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (100) begin @(negedge clk48); if (valid || busy) vcnt++; end
    chk("idle_no_activity", vcnt, 0);

    // Directed values.
    single("d33", 33);
    chk("d33_dx_const", dx_out, 1985);
    chk("d33_u0_const", u0_out, 886302);
    single("d1", 1);
    chk("d1_u0_const", u0_out, 848482);
    single("d0", 0);
    single("d256", 256);
    chk("d256_u0_const", u0_out, 1940992);
    single("d1023", 1023);
    chk("d1023_u0_const", u0_out, 2058112);
    single("d2", 2);

    // Abort: restart with 256 at E+10; only one valid, at E+38.
    hold_dx = 32'(dx_out); hold_u0 = 32'(u0_out);
    single("pre_abort", 33);
    hold_dx = 32'(dx_out); hold_u0 = 32'(u0_out);
    @(negedge clk48);
    start = 1'b1; denom = 10'd33;
    vat = -1; vcnt = 0; hold_ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk48);
      start = 1'b0;
      if (c == 9) begin start = 1'b1; denom = 10'd256; end
      if (valid) begin vcnt++; if (vat < 0) vat = c; end
      if (c < 38 && (32'(dx_out) != hold_dx || 32'(u0_out) != hold_u0)) hold_ok = 1'b0;
      if (c == 38) begin
        chk("abort_dx", dx_out, model_dx(256));
        chk("abort_u0", u0_out, model_u0(256));
      end
    end
    chk("abort_valid_at", vat, 38);
    chk("abort_valid_cnt", vcnt, 1);
    chk("abort_hold", hold_ok, 1);

    // Reset mid-operation clears outputs asynchronously.
    @(negedge clk48);
    start = 1'b1; denom = 10'd5;
    repeat (12) @(negedge clk48);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dx", dx_out, 0);
    chk("async_rst_u0", u0_out, 0);
    @(negedge clk48);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin @(negedge clk48); if (valid) vcnt++; end
    chk("post_rst_no_valid", vcnt, 0);

    // Back-to-back: next start issued in every DONE cycle.
    exp_q.delete();
    vcnt = 0;
    @(negedge clk48);
    d = $urandom_range(0, 1023);
    start = 1'b1; denom = DEN_W'(d); exp_q.push_back(d); sent = 1;
    for (int t = 0; t < 200 * LAT + 60; t++) begin
      @(negedge clk48);           // after edge E0+t
      if (t % LAT == 0) start = 1'b0;
      if (valid) begin
        vcnt++;
        chk("b2b_valid_slot", t % LAT, 0);
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_valid", 1, 0);
        end else begin
          d = exp_q.pop_front();
          chk("b2b_dx", dx_out, model_dx(d));
          chk("b2b_u0", u0_out, model_u0(d));
        end
      end
      if (t % LAT == LAT - 1 && sent < 200) begin
        d = (sent % 50 == 7) ? 0 : ((sent % 50 == 8) ? 1023 : int'($urandom_range(0, 1023)));
        start = 1'b1; denom = DEN_W'(d); exp_q.push_back(d); sent++;
      end
      if (vcnt == 200) break;
    end
    chk("b2b_valid_total", vcnt, 200);
    chk("b2b_queue_empty", exp_q.size(), 0);
    repeat (40) @(negedge clk48);
    chk("b2b_tail_valid", valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
